traffic_phase_arbiter: RTL and testbench

- Intersection phase scheduler that shares the crossing between three requesters: north-south traffic, east-west traffic and the pedestrian crossing.
- Latches requests from vehicle sensors and the pedestrian button, then grants phases in round-robin order.
- Enforces minimum and maximum green times, yellow time and all-red clearance.
- Drives both vehicle signal heads and the walk lamp, and sits above the per-road light drivers.

---
 rtl/traffic_phase_arbiter.sv | 136 +++++++++++++
 tb/tb_traffic_phase_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_arbiter.sv
// Intersection phase scheduler: round-robin between NS traffic, EW traffic and
// the pedestrian crossing, with min/max green, yellow and all-red clearance.
module traffic_phase_arbiter #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       ped_btn,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  // Timer cap is the largest terminal count so no timed state can stall.
  localparam int T_A   = (GREEN_MAX > WALK_T) ? GREEN_MAX : WALK_T;
  localparam int T_B   = (YELLOW_T > ALLRED_T) ? YELLOW_T : ALLRED_T;
  localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;

  typedef enum logic [2:0] {
    ALL_RED   = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    LAST_NS  = 2'd0,
    LAST_EW  = 2'd1,
    LAST_PED = 2'd2
  } last_t;

  state_t        state, state_nxt;
  last_t         last, last_nxt, pick;
  logic [TW-1:0] timer;
  logic          pend_ns, pend_ew, pend_ped;
  logic          serving_ns, serving_ew, serving_ped;
  logic          enter_ns, enter_ew, enter_ped;

  assign serving_ns  = (state == NS_GREEN) || (state == NS_YELLOW);
  assign serving_ew  = (state == EW_GREEN) || (state == EW_YELLOW);
  assign serving_ped = (state == PED_WALK);
  assign enter_ns    = (state_nxt == NS_GREEN) && (state != NS_GREEN);
  assign enter_ew    = (state_nxt == EW_GREEN) && (state != EW_GREEN);
  assign enter_ped   = (state_nxt == PED_WALK) && (state != PED_WALK);

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    pick      = LAST_NS;
    case (state)
      ALL_RED: begin
        if (timer == TW'(ALLRED_T - 1)) begin
          // Search starts one past the last served phase; empty search rests in NS.
          case (last)
            LAST_NS:  pick = pend_ew  ? LAST_EW  : pend_ped ? LAST_PED : LAST_NS;
            LAST_EW:  pick = pend_ped ? LAST_PED : pend_ns  ? LAST_NS  : pend_ew ? LAST_EW : LAST_NS;
            default:  pick = pend_ns  ? LAST_NS  : pend_ew  ? LAST_EW  : pend_ped ? LAST_PED : LAST_NS;
          endcase
          last_nxt = pick;
          case (pick)
            LAST_EW:  state_nxt = EW_GREEN;
            LAST_PED: state_nxt = PED_WALK;
            default:  state_nxt = NS_GREEN;
          endcase
        end
      end
      NS_GREEN: begin
        if ((timer >= TW'(GREEN_MIN - 1)) && (pend_ew || pend_ped) &&
            (!req_ns || (timer == TW'(GREEN_MAX - 1))))
          state_nxt = NS_YELLOW;
      end
      NS_YELLOW: if (timer == TW'(YELLOW_T - 1)) state_nxt = ALL_RED;
      EW_GREEN: begin
        if ((timer >= TW'(GREEN_MIN - 1)) && (pend_ns || pend_ped) &&
            (!req_ew || (timer == TW'(GREEN_MAX - 1))))
          state_nxt = EW_YELLOW;
      end
      EW_YELLOW: if (timer == TW'(YELLOW_T - 1)) state_nxt = ALL_RED;
      PED_WALK:  if (timer == TW'(WALK_T - 1)) state_nxt = ALL_RED;
      default:   state_nxt = ALL_RED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ALL_RED;
      last     <= LAST_PED;
      timer    <= '0;
      pend_ns  <= 1'b0;
      pend_ew  <= 1'b0;
      pend_ped <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      if (state_nxt != state)
        timer <= '0;
      else if (timer != TW'(T_MAX))
        timer <= timer + 1'b1;
      // Entry clear overrides a same-cycle request.
      pend_ns  <= (pend_ns  | (req_ns  & ~serving_ns))  & ~enter_ns;
      pend_ew  <= (pend_ew  | (req_ew  & ~serving_ew))  & ~enter_ew;
      pend_ped <= (pend_ped | (ped_btn & ~serving_ped)) & ~enter_ped;
    end
  end

  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    ped_walk = 1'b0;
    case (state)
      NS_GREEN:  ns_light = LIGHT_GREEN;
      NS_YELLOW: ns_light = LIGHT_YELLOW;
      EW_GREEN:  ew_light = LIGHT_GREEN;
      EW_YELLOW: ew_light = LIGHT_YELLOW;
      PED_WALK:  ped_walk = 1'b1;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Bench for traffic_phase_arbiter: directed scenarios plus random traffic,
// every cycle compared against a cycle-count reference model.
module tb_traffic_phase_arbiter;

  localparam int GREEN_MIN = 8;
  localparam int GREEN_MAX = 20;
  localparam int YELLOW_T  = 3;
  localparam int ALLRED_T  = 2;
  localparam int WALK_T    = 6;

  localparam int S_AR  = 0;
  localparam int S_NSG = 1;
  localparam int S_NSY = 2;
  localparam int S_EWG = 3;
  localparam int S_EWY = 4;
  localparam int S_PED = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_ns = 1'b0;
  logic       req_ew = 1'b0;
  logic       ped_btn = 1'b0;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       ped_walk;
  logic [2:0] phase;

  int checks = 0;
  int failures = 0;

  // Reference model: phase code, cycles spent in it, pending flags, last served.
  int m_state;
  int m_cnt;
  int m_last;
  bit m_p[3];

  always #5 clk = ~clk;

  traffic_phase_arbiter #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .WALK_T(WALK_T)
  ) dut (
    .clk(clk), .rst(rst), .req_ns(req_ns), .req_ew(req_ew), .ped_btn(ped_btn),
    .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk), .phase(phase)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_AR;
    m_cnt   = 0;
    m_last  = 2;
    m_p[0]  = 0;
    m_p[1]  = 0;
    m_p[2]  = 0;
  endtask

  task automatic model_step(input bit rn, input bit re, input bit rp);
    int nxt;
    int pick;
    bit found;
    nxt = m_state;
    case (m_state)
      S_AR: if (m_cnt == ALLRED_T - 1) begin
        pick  = 0;
        found = 0;
        for (int k = 1; k <= 3; k++) begin
          if (!found && m_p[(m_last + k) % 3]) begin
            pick  = (m_last + k) % 3;
            found = 1;
          end
        end
        m_last = pick;
        nxt = (pick == 0) ? S_NSG : (pick == 1) ? S_EWG : S_PED;
      end
      S_NSG: if (m_cnt >= GREEN_MIN - 1 && (m_p[1] || m_p[2]) && (!rn || m_cnt == GREEN_MAX - 1)) nxt = S_NSY;
      S_EWG: if (m_cnt >= GREEN_MIN - 1 && (m_p[0] || m_p[2]) && (!re || m_cnt == GREEN_MAX - 1)) nxt = S_EWY;
      S_NSY, S_EWY: if (m_cnt == YELLOW_T - 1) nxt = S_AR;
      S_PED: if (m_cnt == WALK_T - 1) nxt = S_AR;
      default: nxt = S_AR;
    endcase
    if (rn && m_state != S_NSG && m_state != S_NSY) m_p[0] = 1;
    if (re && m_state != S_EWG && m_state != S_EWY) m_p[1] = 1;
    if (rp && m_state != S_PED) m_p[2] = 1;
    if (nxt != m_state) begin
      m_cnt = 0;
      if (nxt == S_NSG) m_p[0] = 0;
      if (nxt == S_EWG) m_p[1] = 0;
      if (nxt == S_PED) m_p[2] = 0;
    end else begin
      m_cnt++;
    end
    m_state = nxt;
  endtask

  task automatic compare_all();
    check("phase", 32'(phase), 32'(m_state));
    check("ns_light", 32'(ns_light), (m_state == S_NSG) ? 32'd1 : (m_state == S_NSY) ? 32'd2 : 32'd0);
    check("ew_light", 32'(ew_light), (m_state == S_EWG) ? 32'd1 : (m_state == S_EWY) ? 32'd2 : 32'd0);
    check("ped_walk", 32'(ped_walk), 32'(m_state == S_PED));
    check("pend_ns", 32'(dut.pend_ns), 32'(m_p[0]));
    check("pend_ew", 32'(dut.pend_ew), 32'(m_p[1]));
    check("pend_ped", 32'(dut.pend_ped), 32'(m_p[2]));
    check("safe_heads", 32'(ns_light != 2'b00 && ew_light != 2'b00), 32'd0);
    check("safe_walk", 32'(ped_walk && (ns_light != 2'b00 || ew_light != 2'b00)), 32'd0);
  endtask

  // Entered and left at one time unit after a rising edge.
  task automatic tick(input bit rn, input bit re, input bit rp);
    req_ns  = rn;
    req_ew  = re;
    ped_btn = rp;
    @(posedge clk);
    model_step(rn, re, rp);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  task automatic count_phase(input int code, input bit rn, input bit re, output int n);
    n = 0;
    while (32'(phase) == code && n < 200) begin
      tick(rn, re, 1'b0);
      n++;
    end
  endtask

  initial begin
    int n;
    bit rn, re;
    model_reset();

    // Idle release: all-red clearance, then rest in NS green.
    do_reset();
    count_phase(S_AR, 0, 0, n);
    check("t1_allred_len", 32'(n), 32'(ALLRED_T));
    for (int i = 0; i < 30; i++) tick(0, 0, 0);
    check("t1_rest_ns", 32'(phase), 32'(S_NSG));

    // Late EW pulse ends a rested green on the next cycle.
    tick(0, 1, 0);
    count_phase(S_NSG, 0, 0, n);
    check("t2_exit_lat", 32'(n), 32'd1);
    count_phase(S_NSY, 0, 0, n);
    check("t2_yellow_len", 32'(n), 32'(YELLOW_T));
    count_phase(S_AR, 0, 0, n);
    check("t2_allred_len", 32'(n), 32'(ALLRED_T));
    check("t2_ew_green", 32'(phase), 32'(S_EWG));
    check("t2_pend_ew_clr", 32'(dut.pend_ew), 32'd0);

    // Early EW pulse: green still lasts GREEN_MIN.
    do_reset();
    count_phase(S_AR, 0, 0, n);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 0);
    count_phase(S_NSG, 0, 0, n);
    check("t3_green_min", 32'(n + 3), 32'(GREEN_MIN));

    // Held NS demand with pedestrian waiting: capped green, then walk.
    do_reset();
    count_phase(S_AR, 1, 0, n);
    check("t4_allred_len", 32'(n), 32'(ALLRED_T));
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 0, 1);
    count_phase(S_NSG, 1, 0, n);
    check("t4_green_max", 32'(n + 3), 32'(GREEN_MAX));
    count_phase(S_NSY, 1, 0, n);
    check("t4_yellow_len", 32'(n), 32'(YELLOW_T));
    count_phase(S_AR, 1, 0, n);
    check("t4_walk_phase", 32'(phase), 32'(S_PED));
    check("t4_walk_heads", 32'({ns_light, ew_light}), 32'd0);
    count_phase(S_PED, 1, 0, n);
    check("t4_walk_len", 32'(n), 32'(WALK_T));
    count_phase(S_AR, 1, 0, n);
    check("t4_back_ns", 32'(phase), 32'(S_NSG));

    // EW and PED both waiting: EW first; a button press during walk is dropped.
    tick(0, 1, 1);
    count_phase(S_NSG, 0, 0, n);
    count_phase(S_NSY, 0, 0, n);
    count_phase(S_AR, 0, 0, n);
    check("t5_ew_first", 32'(phase), 32'(S_EWG));
    check("t5_ped_waits", 32'(dut.pend_ped), 32'd1);
    count_phase(S_EWG, 0, 0, n);
    count_phase(S_EWY, 0, 0, n);
    count_phase(S_AR, 0, 0, n);
    check("t5_ped_next", 32'(phase), 32'(S_PED));
    tick(0, 0, 1);
    count_phase(S_PED, 0, 0, n);
    check("t5_walk_len", 32'(n + 1), 32'(WALK_T));
    check("t5_ped_ignored", 32'(dut.pend_ped), 32'd0);
    count_phase(S_AR, 0, 0, n);
    check("t5_rest_ns", 32'(phase), 32'(S_NSG));

    // Asynchronous reset during EW yellow with NS and PED pending.
    tick(0, 1, 0);
    count_phase(S_NSG, 0, 0, n);
    count_phase(S_NSY, 0, 0, n);
    count_phase(S_AR, 0, 0, n);
    tick(1, 0, 1);
    count_phase(S_EWG, 0, 0, n);
    check("t6_in_ew_yellow", 32'(phase), 32'(S_EWY));
    check("t6_pend_before", 32'({dut.pend_ns, dut.pend_ped}), 32'd3);
    do_reset();
    count_phase(S_AR, 0, 0, n);
    check("t6_allred_len", 32'(n), 32'(ALLRED_T));
    check("t6_rest_ns", 32'(phase), 32'(S_NSG));

    // Random traffic with occasional mid-run resets.
    rn = 0;
    re = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 7) == 0) rn = ~rn;
        if ($urandom_range(0, 7) == 0) re = ~re;
        tick(rn, re, $urandom_range(0, 19) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
